mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory pipeline stage. Sits directly downstream of EX and upstream of WB.
- Registers the EX→MEM bus and the HI/LO bus under the stall vector.
- Accepts variable-latency read data from data SRAM, extracts and extends load data, and emits the MEM→WB buses.
- Requests a pipeline stall while a load response is outstanding.

Parameters:
- MAX_WAIT, 15: number of cycles a load may wait for rvalid before mem_timeout is set.
- WAIT_CNT_W, 4: width of the saturating wait counter; must satisfy 2^WAIT_CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall  in  6  stall vector; bit 3 = EX, bit 4 = MEM; 1 = Stop
- ex_to_mem_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 treated as none
- hilo_ex_to_mem_bus  in  66  {hi_wdata, lo_wdata, hi_we, lo_we}
- data_sram_rdata  in  32  read data
- data_sram_rvalid  in  1  read data valid; only meaningful while a load is resident in MEM
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- hilo_mem_to_wb_bus  out  66  registered HI/LO bus, passed through unchanged
- mem_wreg / mem_waddr / mem_wdata  out  1/5/32  forwarding to ID; same values as the WB bus fields
- stallreq_for_mem  out  1  stall request to the stall controller
- mem_timeout  out  1  sticky; set when a load waits more than MAX_WAIT cycles

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. All state clears when rst is asserted, independent of clk.
- Reset values: all outputs 0, state IDLE, buffer 0, counter 0, mem_timeout 0.
- Input register, on each posedge:
  - stall[3]=Stop and stall[4]=NoStop → load zeros (bubble).
  - else stall[3]=NoStop → capture both input buses and ex_load_op.
  - else hold.
- load_res = registered data_ram_en & (registered wen == 0) & (load_op in 1..5).
- FSM states:
  - IDLE: no load outstanding, or a non-load is resident.
  - WAIT: load resident, no response yet.
  - HAVE: response captured in the buffer.
- FSM transitions:
  - Register advances (stall[3]=NoStop, or a bubble is inserted) → IDLE, counter cleared.
  - Otherwise, with load_res: IDLE/WAIT with rvalid=1 → HAVE, buffer <= rdata. IDLE/WAIT with rvalid=0 → WAIT, counter increments and saturates.
  - rvalid while in HAVE or without load_res → ignored.
- raw = rvalid ? rdata : buffer; raw is combinational when rvalid=1.
- stallreq_for_mem = load_res & ~rvalid & (state != HAVE), combinational. A single-cycle SRAM, i.e. rvalid in the first MEM cycle, produces no stall.
- Load extraction, addr = ex_result[1:0]:
  - LB/LBU: byte addr selects raw[8*addr+7 : 8*addr]; LB sign-extends, LBU zero-extends.
  - LH/LHU: addr[1] selects the upper or lower halfword; LH sign-extends, LHU zero-extends.
  - LW: raw unchanged.
- Write-back data: rf_wdata = sel_rf_res ? load_data : ex_result.
- While stallreq_for_mem=1: rf_we on the WB bus and mem_wreg are forced to 0.
- Timeout: when the counter reaches MAX_WAIT and state is WAIT, mem_timeout is set to 1 and stays set until reset. The stall continues until rvalid arrives.
- Reset mid-wait: FSM returns to IDLE, buffer is discarded, and any later rvalid is ignored until a new load is resident.

Optional Feature:
- Macro: MEM_ADEL_EN.
- Defined:
  - Adds output mem_adel (1 bit).
  - mem_adel = load_res & ((LH/LHU with addr[0]=1) or (LW with addr≠0)).
  - When mem_adel=1: rf_we and mem_wreg are forced to 0, stallreq_for_mem is 0, and the FSM stays IDLE.
- Undefined: no mem_adel port and no alignment checks; misaligned addresses use the extraction rules above.

Test Plan:
- LW, addr 0x100, rvalid in the same cycle with rdata 0xDEADBEEF → stallreq=0; mem_to_wb_bus rf_wdata=0xDEADBEEF, rf_we=1 next cycle at WB.
- LB addr 0x103, rdata 0x80112233 → rf_wdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x102 → 0x00008011.
- LW with rvalid delayed 3 cycles → stallreq=1 for exactly 3 cycles, forwarding rf_we=0 during them; data correct after release; mem_timeout=0.
- rvalid arrives while stall[4]=Stop from an external source → data goes to the buffer (HAVE); rdata changes to 0 afterwards; the released result is still the captured value.
- No rvalid for 16 cycles with MAX_WAIT=15 → mem_timeout=1 and stays 1. Assert rst asynchronously mid-wait → all outputs 0 immediately, mem_timeout=0.
- Non-load ADDU result 0x12345678 with stall[3]=Stop, stall[4]=NoStop → next cycle the bus is all zeros (bubble). With MEM_ADEL_EN defined, LW at addr 0x101 → mem_adel=1, rf_we=0, no stall.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between EX and WB.
// Registers the EX->MEM and HI/LO buses under the stall vector. It accepts
// variable-latency SRAM read data and extracts and extends the load data.
// It holds the pipeline with stallreq_for_mem while a load response is still
// outstanding.
// Optional feature: define MEM_ADEL_EN to add the mem_adel output, which
// flags misaligned LH/LHU/LW loads.
module mem_stage #(
   parameter int MAX_WAIT   = 15,
   parameter int WAIT_CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [75:0] ex_to_mem_bus,
   input  logic [2:0]  ex_load_op,
   input  logic [65:0] hilo_ex_to_mem_bus,
   input  logic [31:0] data_sram_rdata,
   input  logic        data_sram_rvalid,
   output logic [69:0] mem_to_wb_bus,
   output logic [65:0] hilo_mem_to_wb_bus,
   output logic        mem_wreg,
   output logic [4:0]  mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        stallreq_for_mem,
`ifdef MEM_ADEL_EN
   output logic        mem_adel,
`endif
   output logic        mem_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HAVE} state_t;

   localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] CNT_MAX    = '1;

   logic [75:0]           ex_bus_q, ex_bus_d;
   logic [2:0]            load_op_q, load_op_d;
   logic [65:0]           hilo_q, hilo_d;
   state_t                state_q, state_d;
   logic [31:0]           buf_q, buf_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  timeout_q, timeout_d;

   logic        unused_stall;
   logic        advance;
   logic        load_res;
   logic        adel;
   logic        rf_we_eff;
   logic [31:0] raw;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;

   // Fields of the registered EX->MEM bus
   logic [31:0] pc_w;
   logic        ram_en_w;
   logic [3:0]  ram_wen_w;
   logic        sel_rf_res_w;
   logic        rf_we_w;
   logic [4:0]  rf_waddr_w;
   logic [31:0] ex_result_w;
   logic [1:0]  addr_w;

   assign {pc_w, ram_en_w, ram_wen_w, sel_rf_res_w, rf_we_w, rf_waddr_w, ex_result_w} = ex_bus_q;
   assign addr_w       = ex_result_w[1:0];
   assign unused_stall = ^{stall[5], stall[2:0]};

   // The register moves on whenever EX is not stopped or a bubble is inserted
   assign advance  = ~stall[3] | ~stall[4];
   assign load_res = ram_en_w & (ram_wen_w == 4'd0) & (load_op_q != 3'd0) & (load_op_q <= 3'd5);

`ifdef MEM_ADEL_EN
   assign adel = load_res & ((((load_op_q == 3'd3) || (load_op_q == 3'd4)) && addr_w[0]) ||
                             ((load_op_q == 3'd5) && (addr_w != 2'd0)));
   assign mem_adel = adel;
`else
   assign adel = 1'b0;
`endif

   // A response already captured in HAVE takes precedence over any further rvalid
   assign raw              = (data_sram_rvalid && state_q != S_HAVE) ? data_sram_rdata : buf_q;
   assign stallreq_for_mem = load_res & ~adel & ~data_sram_rvalid & (state_q != S_HAVE);
   assign rf_we_eff        = rf_we_w & ~stallreq_for_mem & ~adel;

   // Select the byte/halfword addressed by the low address bits and extend it
   always_comb begin
      byte_v = raw[7:0];
      case (addr_w)
         2'd0: byte_v = raw[7:0];
         2'd1: byte_v = raw[15:8];
         2'd2: byte_v = raw[23:16];
         2'd3: byte_v = raw[31:24];
         default: byte_v = raw[7:0];
      endcase
      half_v    = addr_w[1] ? raw[31:16] : raw[15:0];
      load_data = 32'd0;
      case (load_op_q)
         3'd1: load_data = {{24{byte_v[7]}}, byte_v};
         3'd2: load_data = {24'd0, byte_v};
         3'd3: load_data = {{16{half_v[15]}}, half_v};
         3'd4: load_data = {16'd0, half_v};
         3'd5: load_data = raw;
         default: load_data = 32'd0;
      endcase
      rf_wdata = sel_rf_res_w ? load_data : ex_result_w;
   end

   assign mem_to_wb_bus      = {pc_w, rf_we_eff, rf_waddr_w, rf_wdata};
   assign hilo_mem_to_wb_bus = hilo_q;
   assign mem_wreg           = rf_we_eff;
   assign mem_waddr          = rf_waddr_w;
   assign mem_wdata          = rf_wdata;
   assign mem_timeout        = timeout_q;

   // Input register: bubble, capture or hold according to the stall vector
   always_comb begin
      ex_bus_d  = ex_bus_q;
      load_op_d = load_op_q;
      hilo_d    = hilo_q;
      if (stall[3] && !stall[4]) begin
         ex_bus_d  = '0;
         load_op_d = '0;
         hilo_d    = '0;
      end else if (!stall[3]) begin
         ex_bus_d  = ex_to_mem_bus;
         load_op_d = ex_load_op;
         hilo_d    = hilo_ex_to_mem_bus;
      end
   end

   // Load response tracking: buffer the early response, count the wait and flag timeouts
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      timeout_d = timeout_q | ((state_q == S_WAIT) && (cnt_q == MAX_WAIT_C));
      if (advance) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         buf_d   = '0;
      end else if (load_res && !adel && state_q != S_HAVE) begin
         if (data_sram_rvalid) begin
            state_d = S_HAVE;
            buf_d   = data_sram_rdata;
         end else begin
            state_d = S_WAIT;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WAIT_CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_bus_q  <= '0;
         load_op_q <= '0;
         hilo_q    <= '0;
         state_q   <= S_IDLE;
         buf_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         ex_bus_q  <= ex_bus_d;
         load_op_q <= load_op_d;
         hilo_q    <= hilo_d;
         state_q   <= state_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases and randomized loads checked
// against an arithmetic reference model of load extraction and stall timing.
module tb_mem_stage;

   localparam int MAX_WAIT = 15;
   localparam logic [5:0] HOLD    = 6'b011111;
   localparam logic [5:0] RELEASE = 6'b000000;
   localparam logic [5:0] BUBBLE  = 6'b001111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic [75:0] ex_to_mem_bus = '0;
   logic [2:0]  ex_load_op = '0;
   logic [65:0] hilo_ex_to_mem_bus = '0;
   logic [31:0] data_sram_rdata = '0;
   logic        data_sram_rvalid = 1'b0;
   logic [69:0] mem_to_wb_bus;
   logic [65:0] hilo_mem_to_wb_bus;
   logic        mem_wreg;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        stallreq_for_mem;
   logic        mem_timeout;
`ifdef MEM_ADEL_EN
   logic        mem_adel;
`endif

   int checks = 0;
   int errors = 0;

   mem_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .ex_to_mem_bus(ex_to_mem_bus),
      .ex_load_op(ex_load_op),
      .hilo_ex_to_mem_bus(hilo_ex_to_mem_bus),
      .data_sram_rdata(data_sram_rdata),
      .data_sram_rvalid(data_sram_rvalid),
      .mem_to_wb_bus(mem_to_wb_bus),
      .hilo_mem_to_wb_bus(hilo_mem_to_wb_bus),
      .mem_wreg(mem_wreg),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .stallreq_for_mem(stallreq_for_mem),
`ifdef MEM_ADEL_EN
      .mem_adel(mem_adel),
`endif
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: value a load of type op at byte offset a delivers from word w
   function automatic logic [31:0] load_model(input logic [2:0] op, input int a, input logic [31:0] w);
      longint v;
      v = 0;
      case (op)
         3'd1, 3'd2: begin
            v = longint'((w >> (8 * a)) & 32'hFF);
            if (op == 3'd1 && v >= 128) v = v - 256;
         end
         3'd3, 3'd4: begin
            v = longint'((w >> ((a >= 2) ? 16 : 0)) & 32'hFFFF);
            if (op == 3'd3 && v >= 32768) v = v - 65536;
         end
         3'd5: v = longint'(w);
         default: v = 0;
      endcase
      return v[31:0];
   endfunction

   function automatic logic [65:0] rand_hilo();
      logic [1:0] we;
      we = 2'($urandom);
      return {$urandom, $urandom, we};
   endfunction

   // One instruction through MEM: resident for `delay` stalled cycles, then the
   // response, then `hold_after` externally held cycles before release.
   task automatic run_inst(input string name, input logic [2:0] op, input logic [31:0] result,
                           input logic [31:0] rd, input int delay, input int hold_after);
      logic [31:0] pc, exp;
      logic [4:0]  waddr;
      logic [65:0] hilo;
      logic        is_load;
      int          d;
      pc      = $urandom;
      waddr   = 5'($urandom);
      hilo    = rand_hilo();
      is_load = (op >= 3'd1 && op <= 3'd5);
      d       = is_load ? delay : 0;
      exp     = is_load ? load_model(op, int'(result[1:0]), rd) : result;
      ex_to_mem_bus      = {pc, is_load, 4'd0, is_load, 1'b1, waddr, result};
      ex_load_op         = op;
      hilo_ex_to_mem_bus = hilo;
      stall              = RELEASE;
      data_sram_rvalid   = 1'b0;
      @(posedge clk); #1;
      ex_to_mem_bus      = '0;
      ex_load_op         = '0;
      hilo_ex_to_mem_bus = '0;
      for (int i = 0; i < d; i++) begin
         data_sram_rvalid = 1'b0;
         data_sram_rdata  = $urandom;
         stall            = HOLD;
         @(negedge clk);
         checks++;
         if (stallreq_for_mem !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_stall cyc%0d: got %b expected 1", name, i, stallreq_for_mem);
         end
         checks++;
         if (mem_wreg !== 1'b0 || mem_to_wb_bus[37] !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_we cyc%0d: got wreg=%b bus_we=%b expected 0", name, i, mem_wreg, mem_to_wb_bus[37]);
         end
         @(posedge clk); #1;
      end
      for (int c = 0; c <= hold_after; c++) begin
         if (c == 0) begin
            data_sram_rvalid = is_load ? 1'b1 : 1'($urandom);
            data_sram_rdata  = is_load ? rd : $urandom;
         end else begin
            data_sram_rvalid = 1'b0;
            data_sram_rdata  = 32'd0;
         end
         stall = (c == hold_after) ? RELEASE : HOLD;
         @(negedge clk);
         checks++;
         if (stallreq_for_mem !== 1'b0) begin
            errors++;
            $display("FAIL %s stallreq c%0d: got %b expected 0", name, c, stallreq_for_mem);
         end
         checks++;
         if (mem_to_wb_bus !== {pc, 1'b1, waddr, exp}) begin
            errors++;
            $display("FAIL %s wb_bus c%0d: got %h expected %h", name, c, mem_to_wb_bus, {pc, 1'b1, waddr, exp});
         end
         checks++;
         if (mem_wreg !== 1'b1 || mem_waddr !== waddr || mem_wdata !== exp) begin
            errors++;
            $display("FAIL %s fwd c%0d: got %b/%h/%h expected 1/%h/%h", name, c, mem_wreg, mem_waddr, mem_wdata, waddr, exp);
         end
         checks++;
         if (hilo_mem_to_wb_bus !== hilo) begin
            errors++;
            $display("FAIL %s hilo c%0d: got %h expected %h", name, c, hilo_mem_to_wb_bus, hilo);
         end
         checks++;
         if (mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout c%0d: got %b expected 0", name, c, mem_timeout);
         end
         @(posedge clk); #1;
      end
      data_sram_rvalid = 1'b0;
      $display("txn %s op=%0d addr=%h rdata=%h delay=%0d hold=%0d wdata=%h", name, op, result, rd, d, hold_after, exp);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata, stallreq_for_mem, mem_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got bus=%h hilo=%h stall=%b to=%b expected all 0",
                  mem_to_wb_bus, hilo_mem_to_wb_bus, stallreq_for_mem, mem_timeout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("txn reset done");
   endtask

   task automatic test_plan_loads();
      run_inst("lw_same_cycle", 3'd5, 32'h100, 32'hDEADBEEF, 0, 0);
      run_inst("lb_neg", 3'd1, 32'h103, 32'h80112233, 0, 0);
      run_inst("lbu", 3'd2, 32'h103, 32'h80112233, 0, 0);
      run_inst("lhu_upper", 3'd4, 32'h102, 32'h80112233, 0, 0);
      run_inst("lh_lower_neg", 3'd3, 32'h200, 32'h1234F00D, 1, 0);
      run_inst("lw_delay3", 3'd5, 32'h104, 32'hCAFEF00D, 3, 0);
   endtask

   task automatic test_buffer();
      run_inst("rvalid_under_ext_stall", 3'd5, 32'h108, 32'h5A5AA5A5, 2, 3);
      run_inst("lb_buffered", 3'd1, 32'h109, 32'h00007F00, 0, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         op   = 3'($urandom);
         addr = $urandom;
`ifdef MEM_ADEL_EN
         if (op == 3'd3 || op == 3'd4) addr[0] = 1'b0;
         if (op == 3'd5) addr[1:0] = 2'b00;
`endif
         run_inst("random", op, addr, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++)
         run_inst("b2b", 3'd5, 32'h400 + 32'(4 * n), $urandom, 0, 0);
   endtask

   task automatic test_bubble();
      run_inst("addu", 3'd0, 32'h12345678, 32'd0, 0, 0);
      ex_to_mem_bus      = {32'h0000_0040, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'h12345678};
      ex_load_op         = 3'd0;
      hilo_ex_to_mem_bus = rand_hilo();
      stall              = RELEASE;
      @(posedge clk); #1;
      stall = BUBBLE;
      @(negedge clk);
      checks++;
      if (mem_wdata !== 32'h12345678 || mem_wreg !== 1'b1) begin
         errors++;
         $display("FAIL bubble_pre: got wdata=%h wreg=%b expected 12345678/1", mem_wdata, mem_wreg);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== '0 || hilo_mem_to_wb_bus !== '0) begin
         errors++;
         $display("FAIL bubble_zero: got bus=%h hilo=%h expected 0", mem_to_wb_bus, hilo_mem_to_wb_bus);
      end
      @(posedge clk); #1;
      stall = RELEASE;
      ex_to_mem_bus = '0;
      hilo_ex_to_mem_bus = '0;
      $display("txn bubble inserted");
   endtask

`ifdef MEM_ADEL_EN
   task automatic test_adel();
      ex_to_mem_bus = {32'h0000_0080, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h101};
      ex_load_op    = 3'd5;
      stall         = RELEASE;
      @(posedge clk); #1;
      ex_to_mem_bus = '0;
      ex_load_op    = '0;
      data_sram_rvalid = 1'b0;
      stall = HOLD;
      @(negedge clk);
      checks++;
      if (mem_adel !== 1'b1 || mem_wreg !== 1'b0 || stallreq_for_mem !== 1'b0 || mem_to_wb_bus[37] !== 1'b0) begin
         errors++;
         $display("FAIL adel_lw: got adel=%b wreg=%b stall=%b expected 1/0/0", mem_adel, mem_wreg, stallreq_for_mem);
      end
      @(posedge clk); #1;
      stall = RELEASE;
      @(posedge clk); #1;
      $display("txn adel lw 0x101");
   endtask
`endif

   // Timeout is sticky and raised once a load has waited more than MAX_WAIT cycles;
   // an asynchronous reset mid-wait clears everything immediately.
   task automatic test_timeout_reset();
      ex_to_mem_bus = {32'h0000_0100, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h300};
      ex_load_op    = 3'd5;
      stall         = RELEASE;
      @(posedge clk); #1;
      ex_to_mem_bus = '0;
      ex_load_op    = '0;
      for (int i = 0; i < MAX_WAIT + 5; i++) begin
         data_sram_rvalid = 1'b0;
         stall = HOLD;
         @(negedge clk);
         checks++;
         if (mem_timeout !== ((i > MAX_WAIT) ? 1'b1 : 1'b0) || stallreq_for_mem !== 1'b1) begin
            errors++;
            $display("FAIL timeout cyc%0d: got to=%b stall=%b expected to=%b stall=1",
                     i, mem_timeout, stallreq_for_mem, (i > MAX_WAIT));
         end
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_wdata, stallreq_for_mem, mem_timeout} !== '0) begin
         errors++;
         $display("FAIL async_reset: got bus=%h stall=%b to=%b expected all 0", mem_to_wb_bus, stallreq_for_mem, mem_timeout);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = $urandom;
      stall = HOLD;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== '0 || stallreq_for_mem !== 1'b0 || mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL stray_rvalid: got bus=%h stall=%b to=%b expected 0", mem_to_wb_bus, stallreq_for_mem, mem_timeout);
      end
      @(posedge clk); #1;
      data_sram_rvalid = 1'b0;
      stall = RELEASE;
      run_inst("lw_after_reset", 3'd5, 32'h500, 32'h0BADF00D, 1, 0);
      $display("txn timeout and async reset");
   endtask

   initial begin
      test_reset();
      test_plan_loads();
      test_buffer();
      test_random();
      test_back_to_back();
      test_bubble();
`ifdef MEM_ADEL_EN
      test_adel();
`endif
      test_timeout_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
